karatsuba_combine_seq: RTL and testbench

- Consumes the registered 16-bit halves (xl, xr, yl, yr) from the operand-split stage.
- Produces the full 64-bit product of the original 32-bit operands x = {xl,xr}, y = {yl,yr}.
- Uses one shared 17x17 multiplier over three cycles: z2 = xl*yl, z0 = xr*yr, zm = (xl+xr)*(yl+yr).
- Recombines as p = (z2<<32) + ((zm-z2-z0)<<16) + z0 and returns the result under a valid/ready handshake.

---
 rtl/karatsuba_combine_seq.sv | 101 ++++++++++
 tb/tb_karatsuba_combine_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/karatsuba_combine_seq.sv
// karatsuba_combine_seq: 32x32 multiply through one shared 17x17 multiplier over three cycles, Karatsuba recombine, valid/ready handshake.
// Ports: clk; rst (async active-low); in_valid/in_ready with xl,xr,yl,yr halves; out_valid/out_ready with 64b product p; busy (not IDLE); err (sticky self-check flag).
// Optional: define KARATSUBA_CHECK_EN to build a direct-product checker driving err; otherwise err is tied to 0.
module karatsuba_combine_seq #(
  parameter int HW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [HW-1:0]   xl,
  input  logic [HW-1:0]   xr,
  input  logic [HW-1:0]   yl,
  input  logic [HW-1:0]   yr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*HW-1:0] p,
  output logic            busy,
  output logic            err
);
  typedef enum logic [2:0] {IDLE, MUL_HI, MUL_LO, MUL_MID, COMBINE, DONE} state_t;
  state_t state;
  logic [HW-1:0] xl_q, xr_q, yl_q, yr_q;
  logic [2*HW-1:0] z2, z0;
  logic [2*HW+1:0] zm, mid, prod;
  logic [HW:0] sx, sy, ma, mb;
  logic [4*HW-1:0] p_next;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign sx = {1'b0, xl_q} + {1'b0, xr_q};
  assign sy = {1'b0, yl_q} + {1'b0, yr_q};
  // One multiplier shared by the three MUL states; MUL_MID takes the 17b sums.
  always_comb begin
    ma = state == MUL_HI ? {1'b0, xl_q} : state == MUL_LO ? {1'b0, xr_q} : sx;
    mb = state == MUL_HI ? {1'b0, yl_q} : state == MUL_LO ? {1'b0, yr_q} : sy;
  end
  assign prod = (2*HW+2)'(ma) * (2*HW+2)'(mb);
  // zm >= z2 + z0 always, so the 34b middle term never wraps.
  assign mid = zm - (2*HW+2)'(z2) - (2*HW+2)'(z0);
  assign p_next = {z2, {(2*HW){1'b0}}} + ((4*HW)'(mid) << HW) + (4*HW)'(z0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      xl_q <= '0;
      xr_q <= '0;
      yl_q <= '0;
      yr_q <= '0;
      z2 <= '0;
      z0 <= '0;
      zm <= '0;
      p <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xl_q <= xl;
          xr_q <= xr;
          yl_q <= yl;
          yr_q <= yr;
          state <= MUL_HI;
        end
        MUL_HI: begin
          z2 <= prod[2*HW-1:0];
          state <= MUL_LO;
        end
        MUL_LO: begin
          z0 <= prod[2*HW-1:0];
          state <= MUL_MID;
        end
        MUL_MID: begin
          zm <= prod;
          state <= COMBINE;
        end
        COMBINE: begin
          p <= p_next;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef KARATSUBA_CHECK_EN
  logic [4*HW-1:0] ref_p;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_p <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) ref_p <= (4*HW)'({xl, xr}) * (4*HW)'({yl, yr});
      if (state == COMBINE && p_next != ref_p) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_karatsuba_combine_seq.sv
// tb_karatsuba_combine_seq: randomized and directed self-checking bench against a plain x*y reference.
module tb_karatsuba_combine_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] xl = '0, xr = '0, yl = '0, yr = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [63:0] p;
  logic busy, err;
  int n_pass = 0;
  int n_total = 0;

  karatsuba_combine_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .xl(xl), .xr(xr), .yl(yl), .yr(yr),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Presents one operand set from a negedge, returns the product and the number of edges from accept to out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold,
                        output logic [63:0] got, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    {xl, xr} = x;
    {yl, yr} = y;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    got = p;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (p !== 64'd0) $display("FAIL reset_p got %h want 0", p); else n_pass++;
    n_total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL reset_busy_err got %b%b want 00", busy, err); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] got;
    int lat;
    run_op(32'h0001_0000, 32'h0001_0000, 0, got, lat);
    n_total++; if (got !== 64'h0000_0001_0000_0000) $display("FAIL unit_p got %h want %h", got, 64'h0000_0001_0000_0000); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL unit_latency got %0d want 4", lat); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL unit_err got %b want 0", err); else n_pass++;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, got, lat);
    n_total++; if (got !== model(32'hFFFF_FFFF, 32'hFFFF_FFFF)) $display("FAIL carry_p got %h want %h", got, model(32'hFFFF_FFFF, 32'hFFFF_FFFF)); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL carry_latency got %0d want 4", lat); else n_pass++;
    run_op(32'h0, 32'h0, 0, got, lat);
    n_total++; if (got !== 64'd0 || lat !== 4) $display("FAIL zero_p got %h lat %0d want 0 lat 4", got, lat); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp = model(32'h1234_5678, 32'h9ABC_DEF0);
    int lat = 0;
    int bad = 0;
    {xl, xr} = 32'h1234_5678;
    {yl, yr} = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_total++; if (p !== exp || lat !== 4) $display("FAIL bp_p got %h lat %0d want %h lat 4", p, lat, exp); else n_pass++;
    {xl, xr} = 32'h5;
    {yl, yr} = 32'h6;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ps[$];
    int acc[2];
    int n_acc = 0;
    int cyc = 0;
    {xl, xr} = 32'd3;
    {yl, yr} = 32'd5;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (ps.size() < 2 && cyc < 40) begin
      if (in_ready && n_acc < 2) begin acc[n_acc] = cyc; n_acc++; end
      @(negedge clk);
      cyc++;
      if (out_valid) ps.push_back(p);
      if (n_acc == 1) begin {xl, xr} = 32'd7; {yl, yr} = 32'd11; end
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_total++; if (ps.size() !== 2) $display("FAIL b2b_count got %0d want 2", ps.size());
    else begin
      n_pass++;
      n_total++; if (ps[0] !== model(3, 5)) $display("FAIL b2b_p0 got %h want %h", ps[0], model(3, 5)); else n_pass++;
      n_total++; if (ps[1] !== model(7, 11)) $display("FAIL b2b_p1 got %h want %h", ps[1], model(7, 11)); else n_pass++;
    end
    n_total++; if (n_acc !== 2 || acc[1] - acc[0] !== 6) $display("FAIL b2b_interval got %0d want 6", acc[1] - acc[0]); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    int lat;
    {xl, xr} = 32'hDEAD_BEEF;
    {yl, yr} = 32'hCAFE_F00D;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || p !== 64'd0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL midreset got ov=%b p=%h busy=%b ir=%b want 0 0 0 1", out_valid, p, busy, in_ready); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL midreset_no_pulse got %b want 0", out_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    run_op(32'd2, 32'd2, 0, got, lat);
    n_total++; if (got !== 64'd4 || lat !== 4) $display("FAIL after_reset got %h lat %0d want 4 lat 4", got, lat); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] got;
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 7 == 0) x[15:0] = 16'hFFFF;
      if (i % 11 == 0) y[31:16] = 16'hFFFF;
      run_op(x, y, $urandom_range(0, 2), got, lat);
      n_total++; if (got !== model(x, y)) $display("FAIL rand_p x=%h y=%h got %h want %h", x, y, got, model(x, y)); else n_pass++;
      n_total++; if (lat !== 4) $display("FAIL rand_latency got %0d want 4", lat); else n_pass++;
    end
    n_total++; if (err !== 1'b0) $display("FAIL rand_err got %b want 0", err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
